// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// queue in a FIFO and drain into idle slots or via a forced stall. Optional: WB_PORT_ARB_PERF_EN.
module wb_port_arb #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_data,
  output logic                     lu_ready,
  input  logic [4:0]               chk_rd,
  output logic                     chk_hit,
  output logic                     rf_wen,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     wb_stall,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef WB_PORT_ARB_PERF_EN
  ,
  output logic [31:0]              perf_stall_cyc,
  output logic [31:0]              perf_lu_writes
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {StIdle, StPend, StDrain} state_e;

  state_e          state_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q;
  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic            full, empty, push, pop, starved;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign lu_ready = !full;
  // x0 results complete the handshake but never occupy an entry
  assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop      = !empty && (wb_stall || !wb_wen);
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  assign fifo_cnt = cnt_q;
  assign starved  = (starve_q >= SW'(STARVE_MAX - 1)) && !pop;

  always_comb begin
    chk_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && (rd_mem[rptr_q + PW'(i)] == chk_rd) && (chk_rd != 5'd0)) begin
        chk_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= lu_rd;
      data_mem[wptr_q] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
      wb_stall <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;

      if (pop) begin
        rf_wen   <= 1'b1;
        rf_waddr <= rd_mem[rptr_q];
        rf_wdata <= data_mem[rptr_q];
      end else if (!wb_stall && wb_wen && (wb_rd != 5'd0)) begin
        rf_wen   <= 1'b1;
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end else begin
        rf_wen   <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          starve_q <= '0;
          if (push) state_q <= StPend;
        end
        StPend: begin
          if (cnt_d == '0) begin
            state_q  <= StIdle;
            starve_q <= '0;
          end else if (full || starved) begin
            state_q  <= StDrain;
            wb_stall <= 1'b1;
            starve_q <= '0;
          end else if (pop) begin
            starve_q <= '0;
          end else if (starve_q != {SW{1'b1}}) begin
            starve_q <= starve_q + 1'b1;
          end
        end
        StDrain: begin
          // stall drops on the same edge that retires the last entry
          if (cnt_d == '0) begin
            state_q  <= StIdle;
            wb_stall <= 1'b0;
            starve_q <= '0;
          end
        end
        default: begin
          state_q  <= StIdle;
          wb_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_PORT_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= 32'd0;
      perf_lu_writes <= 32'd0;
    end else begin
      if (wb_stall) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (pop)      perf_lu_writes <= perf_lu_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed self-checking bench for wb_port_arb (DEPTH=4, STARVE_MAX=8).
module tb_wb_port_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = 5'd0;
  logic [31:0] lu_data = 32'd0;
  logic        lu_ready;
  logic [4:0]  chk_rd = 5'd0;
  logic        chk_hit;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [2:0]  fifo_cnt;

  int errors = 0;
  int checks = 0;
  int stall_n;
  logic [36:0] wq[$];

  always #5 clk = ~clk;

  wb_port_arb #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .chk_rd(chk_rd), .chk_hit(chk_hit), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_stall(wb_stall), .fifo_cnt(fifo_cnt)
  );

  // advance one edge, sample 1ns later and log rf writes / stall cycles
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rf_wen) wq.push_back({rf_waddr, rf_wdata});
    if (wb_stall) stall_n++;
  endtask

  task automatic clear_log();
    wq.delete();
    stall_n = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rf: got wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (wb_stall !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b cnt=%0d want 0/0", wb_stall, fifo_cnt);
    end
    checks++;
    if (lu_ready !== 1'b1 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got ready=%b hit=%b want 1/0", lu_ready, chk_hit);
    end
  endtask

  task automatic test_free_drain();
    wb_wen = 1'b0; lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
    cyc();
    lu_valid = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd1) begin
      errors++;
      $display("FAIL free_cnt1: got %0d want 1", fifo_cnt);
    end
    cyc();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL free_write: got wen=%b addr=%0d data=%h want 1/5/deadbeef",
               rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (fifo_cnt !== 3'd0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL free_after: got cnt=%0d stall=%b want 0/0", fifo_cnt, wb_stall);
    end
  endtask

  task automatic test_starve();
    int n3;
    wb_wen = 1'b0; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_0077;
    cyc();
    lu_valid = 1'b0;
    wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    clear_log();
    repeat (12) cyc();
    n3 = 0;
    for (int i = 0; i < wq.size() && wq[i][36:32] == 5'd3; i++) n3++;
    checks++;
    if (n3 != 8) begin
      errors++;
      $display("FAIL starve_pipe_writes: got %0d want 8", n3);
    end
    checks++;
    if (wq.size() < 9 || wq[8] !== {5'd7, 32'h0000_0077}) begin
      errors++;
      $display("FAIL starve_lu_write: got %h want %h", (wq.size() > 8) ? wq[8] : 37'h0,
               {5'd7, 32'h0000_0077});
    end
    checks++;
    if (stall_n != 1 || wb_stall !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL starve_stall: got stalls=%0d stall=%b cnt=%0d want 1/0/0",
               stall_n, wb_stall, fifo_cnt);
    end
  endtask

  task automatic push4();
    wb_wen = 1'b1; wb_rd = 5'd20; wb_data = 32'h2020;
    for (int i = 1; i <= 4; i++) begin
      lu_valid = 1'b1; lu_rd = 5'(i); lu_data = 32'h100 + 32'(i);
      cyc();
    end
  endtask

  task automatic test_full_drain();
    int k;
    clear_log();
    push4();
    checks++;
    if (lu_ready !== 1'b0 || fifo_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_ready: got ready=%b cnt=%0d want 0/4", lu_ready, fifo_cnt);
    end
    lu_valid = 1'b0;
    repeat (10) cyc();
    k = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i][36:32] != 5'd20) begin
        checks++;
        if (wq[i] !== {5'(k + 1), 32'h100 + 32'(k + 1)}) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h want %h", k, wq[i],
                   {5'(k + 1), 32'h100 + 32'(k + 1)});
        end
        k++;
      end
    end
    checks++;
    if (k != 4 || stall_n != 4) begin
      errors++;
      $display("FAIL full_counts: got writes=%0d stalls=%0d want 4/4", k, stall_n);
    end
    checks++;
    if (lu_ready !== 1'b1 || fifo_cnt !== 3'd0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL full_after: got ready=%b cnt=%0d stall=%b want 1/0/0",
               lu_ready, fifo_cnt, wb_stall);
    end
  endtask

  task automatic test_x0();
    wb_wen = 1'b1; wb_rd = 5'd0; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h1234;
    cyc();
    checks++;
    if (fifo_cnt !== 3'd0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL x0_push: got cnt=%0d wen=%b want 0/0", fifo_cnt, rf_wen);
    end
    lu_rd = 5'd9; lu_data = 32'h9999;
    cyc();
    lu_valid = 1'b0;
    cyc();
    checks++;
    if (rf_wen !== 1'b0 || fifo_cnt !== 3'd1) begin
      errors++;
      $display("FAIL x0_slot: got wen=%b cnt=%0d want 0/1", rf_wen, fifo_cnt);
    end
  endtask

  task automatic test_chk_hit();
    chk_rd = 5'd9; #1;
    checks++;
    if (chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL chk_hit9: got %b want 1", chk_hit);
    end
    chk_rd = 5'd10; #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_hit10: got %b want 0", chk_hit);
    end
    chk_rd = 5'd0; #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_hit0: got %b want 0", chk_hit);
    end
    chk_rd = 5'd9; wb_wen = 1'b0; #1;
    checks++;
    if (chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL chk_hit_popping: got %b want 1", chk_hit);
    end
    cyc();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_after_pop: got wen=%b addr=%0d data=%h hit=%b want 1/9/9999/0",
               rf_wen, rf_waddr, rf_wdata, chk_hit);
    end
    chk_rd = 5'd0;
  endtask

  task automatic test_reset_mid_drain();
    int t;
    push4();
    lu_valid = 1'b0;
    t = 0;
    while (!wb_stall && t < 10) begin
      cyc();
      t++;
    end
    cyc();
    checks++;
    if (wb_stall !== 1'b1 || fifo_cnt !== 3'd3) begin
      errors++;
      $display("FAIL mid_drain_setup: got stall=%b cnt=%0d want 1/3", wb_stall, fifo_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || wb_stall !== 1'b0 ||
        fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got wen=%b addr=%0d data=%h stall=%b cnt=%0d want all 0",
               rf_wen, rf_waddr, rf_wdata, wb_stall, fifo_cnt);
    end
    #3 rst = 1'b0;
    wb_wen = 1'b0;
    clear_log();
    repeat (4) cyc();
    checks++;
    if (lu_ready !== 1'b1 || fifo_cnt !== 3'd0 || wq.size() != 0 || stall_n != 0) begin
      errors++;
      $display("FAIL reset_discard: got ready=%b cnt=%0d writes=%0d stalls=%0d want 1/0/0/0",
               lu_ready, fifo_cnt, wq.size(), stall_n);
    end
  endtask

  initial begin
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_free_drain();
    test_starve();
    test_full_drain();
    test_x0();
    test_chk_hit();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
